// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: accepts a word over valid/ready and
// streams it one bit per clock, gap-free back to back, with a start-of-word flag.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no word in flight, out = IDLE_LEVEL, ready for a new word
// SHIFT | bit cnt of the current word is on out; ready on last bit
module piso_shift_reg #(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             sof,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt, sreg_shifted;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             out_nxt;
    logic             last_bit;
    logic             load;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    assign sreg_shifted = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
    assign last_bit     = (state == SHIFT) && (cnt == LAST);
    assign din_ready    = (state == IDLE) || last_bit;
    assign load         = din_valid && din_ready;

    assign out_valid = (state == SHIFT);
    assign busy      = out_valid;
    assign sof       = (state == SHIFT) && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            out   <= IDLE_LEVEL;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            out   <= out_nxt;
        end
    end

    // out is registered from the head of sreg so it never glitches
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        out_nxt   = out;
        if (load) begin
            state_nxt = SHIFT;
            sreg_nxt  = din;
            cnt_nxt   = '0;
            out_nxt   = head_bit(din);
        end else if (state == SHIFT) begin
            if (last_bit) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                out_nxt   = IDLE_LEVEL;
            end else begin
                sreg_nxt = sreg_shifted;
                cnt_nxt  = cnt + CW'(1);
                out_nxt  = head_bit(sreg_shifted);
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: MSB-first and LSB-first instances
// driven in parallel and compared against a queue-of-bits transmit model.
module tb_piso_shift_reg;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;

    logic rdy_m, out_m, ov_m, sof_m, busy_m;
    logic rdy_l, out_l, ov_l, sof_l, busy_l;

    int errors = 0;
    int checks = 0;

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .out(out_m), .out_valid(ov_m), .sof(sof_m), .busy(busy_m)
    );

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .out(out_l), .out_valid(ov_l), .sof(sof_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    // Model: queue of bits still to appear on out; the head is the bit shown now.
    typedef struct {
        logic bm;
        logic bl;
        logic s;
    } ent_t;
    ent_t mq[$];
    ent_t e;
    bit   m_rdy;
    bit   accepted;

    always @(negedge rst) mq.delete();

    always @(posedge clk) begin
        if (rst) begin
            m_rdy    = (mq.size() <= 1);
            accepted = 1'b0;
            if (mq.size() > 0) void'(mq.pop_front());
            if (din_valid && m_rdy) begin
                accepted = 1'b1;
                for (int i = 0; i < W; i++) begin
                    e.bm = din[W-1-i];
                    e.bl = din[i];
                    e.s  = (i == 0);
                    mq.push_back(e);
                end
            end
        end
    end

    function automatic logic x_out_m();
        return (mq.size() > 0) ? mq[0].bm : 1'b0;
    endfunction
    function automatic logic x_out_l();
        return (mq.size() > 0) ? mq[0].bl : 1'b0;
    endfunction
    function automatic logic x_valid();
        return mq.size() > 0;
    endfunction
    function automatic logic x_sof();
        return (mq.size() > 0) ? mq[0].s : 1'b0;
    endfunction
    function automatic logic x_ready();
        return mq.size() <= 1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_m !== 1'b0) begin errors++; $display("FAIL reset_out: got %b want 0", out_m); end
        checks++; if (ov_m !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov_m); end
        checks++; if (sof_m !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b want 0", sof_m); end
        checks++; if (busy_m !== 1'b0 || busy_l !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b want 0/0", busy_m, busy_l); end
        rst = 1'b1;
        #1;
        checks++; if (rdy_m !== 1'b1 || rdy_l !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b/%b want 1/1", rdy_m, rdy_l); end
    endtask

    task automatic test_single();
        logic [3:0] exp_m;
        logic [3:0] exp_l;
        exp_m = 4'b1000;
        exp_l = 4'b0001;
        @(negedge clk);
        din = 4'b1000;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_m !== exp_m[3-i] || out_l !== exp_l[3-i]) begin errors++; $display("FAIL single_bit%0d: got %b/%b want %b/%b", i, out_m, out_l, exp_m[3-i], exp_l[3-i]); end
            checks++; if (sof_m !== (i == 0) || ov_m !== 1'b1) begin errors++; $display("FAIL single_flags%0d: sof=%b valid=%b want sof=%b valid=1", i, sof_m, ov_m, (i == 0)); end
            @(negedge clk);
        end
        checks++; if (ov_m !== 1'b0 || rdy_m !== 1'b1 || out_m !== 1'b0) begin errors++; $display("FAIL single_idle: valid=%b ready=%b out=%b want 0 1 0", ov_m, rdy_m, out_m); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        pat = 8'b1010_0101;
        din = 4'hA;
        din_valid = 1'b1;
        @(negedge clk);
        din = 4'h5;
        for (int i = 0; i < 8; i++) begin
            checks++; if (ov_m !== 1'b1 || out_m !== pat[7-i]) begin errors++; $display("FAIL b2b_bit%0d: valid=%b out=%b want 1 %b", i, ov_m, out_m, pat[7-i]); end
            checks++; if (sof_m !== (i % 4 == 0)) begin errors++; $display("FAIL b2b_sof%0d: got %b want %b", i, sof_m, (i % 4 == 0)); end
            if (i == 4) din_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (ov_m !== 1'b0) begin errors++; $display("FAIL b2b_end: valid=%b want 0", ov_m); end
    endtask

    task automatic test_holdoff();
        din = 4'h9;
        din_valid = 1'b1;
        @(negedge clk);
        din = 4'hF;
        @(negedge clk);
        checks++; if (rdy_m !== 1'b0 || out_m !== 1'b0 || sof_m !== 1'b0) begin errors++; $display("FAIL holdoff_cnt1: ready=%b out=%b sof=%b want 0 0 0", rdy_m, out_m, sof_m); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (rdy_m !== 1'b1 || out_m !== 1'b1) begin errors++; $display("FAIL holdoff_last: ready=%b out=%b want 1 1", rdy_m, out_m); end
        @(negedge clk);
        din_valid = 1'b0;
        checks++; if (sof_m !== 1'b1) begin errors++; $display("FAIL holdoff_sof: got %b want 1", sof_m); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_m !== 1'b1 || ov_m !== 1'b1) begin errors++; $display("FAIL holdoff_F%0d: out=%b valid=%b want 1 1", i, out_m, ov_m); end
            @(negedge clk);
        end
        checks++; if (ov_m !== 1'b0) begin errors++; $display("FAIL holdoff_end: valid=%b want 0", ov_m); end
    endtask

    task automatic test_reset_midword();
        logic [3:0] exp;
        exp = 4'b0011;
        din = 4'hA;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_m !== 1'b0 || ov_m !== 1'b0 || sof_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL midrst_outputs: out=%b valid=%b sof=%b busy=%b want 0000", out_m, ov_m, sof_m, busy_m); end
        @(negedge clk);
        rst = 1'b1;
        din = 4'h3;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_m !== exp[3-i] || sof_m !== (i == 0)) begin errors++; $display("FAIL midrst_bit%0d: out=%b sof=%b want %b %b", i, out_m, sof_m, exp[3-i], (i == 0)); end
            @(negedge clk);
        end
    endtask

    task automatic test_loopback();
        logic [3:0] rx_m;
        logic [3:0] rx_l;
        int n;
        rx_m = '0;
        rx_l = '0;
        n = 0;
        din = 4'hC;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 10 && n < 4; i++) begin
            if (ov_m === 1'b1) begin
                rx_m = {rx_m[2:0], out_m};
                rx_l = {rx_l[2:0], out_l};
                n++;
            end
            @(negedge clk);
        end
        checks++; if (n != 4) begin errors++; $display("FAIL loop_count: got %0d bits want 4", n); end
        checks++; if (rx_m !== 4'hC) begin errors++; $display("FAIL loop_msb: got %h want c", rx_m); end
        checks++; if (rx_l !== 4'h3) begin errors++; $display("FAIL loop_lsb: got %h want 3", rx_l); end
    endtask

    task automatic test_random();
        din_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 600; c++) begin
            checks++; if (out_m !== x_out_m() || out_l !== x_out_l()) begin errors++; $display("FAIL rnd_out c%0d: got %b/%b want %b/%b", c, out_m, out_l, x_out_m(), x_out_l()); end
            checks++; if (ov_m !== x_valid() || ov_l !== x_valid() || busy_m !== x_valid() || busy_l !== x_valid()) begin errors++; $display("FAIL rnd_valid c%0d: got %b%b%b%b want %b", c, ov_m, ov_l, busy_m, busy_l, x_valid()); end
            checks++; if (sof_m !== x_sof() || sof_l !== x_sof()) begin errors++; $display("FAIL rnd_sof c%0d: got %b/%b want %b", c, sof_m, sof_l, x_sof()); end
            checks++; if (rdy_m !== x_ready() || rdy_l !== x_ready()) begin errors++; $display("FAIL rnd_ready c%0d: got %b/%b want %b", c, rdy_m, rdy_l, x_ready()); end
            if (accepted) din_valid = 1'b0;
            if (!din_valid) begin
                din = W'($urandom);
                if ($urandom_range(0, 2) != 0) din_valid = 1'b1;
            end
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b0;
                accepted = 1'b0;
                #1;
                checks++; if (ov_m !== 1'b0 || out_m !== 1'b0 || sof_m !== 1'b0) begin errors++; $display("FAIL rnd_rst c%0d: valid=%b out=%b sof=%b want 000", c, ov_m, out_m, sof_m); end
                @(negedge clk);
                rst = 1'b1;
            end
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_holdoff();
        test_reset_midword();
        test_loopback();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
